edge_detector_bank: RTL

- Parametrised multi-channel successor to the single-bit posedge/negedge detectors.
- Each channel does the following:
  - synchronises an asynchronous input;
  - debounces it with a stability filter;
  - emits one-cycle rise/fall/event pulses, selectable per channel.
- Events are latched into sticky flags, combined into a maskable interrupt.
- Sits between raw pins/async status lines and control FSMs or an interrupt controller.

---
 rtl/edge_pkg.sv | 8 +
 rtl/edge_chan.sv | 62 ++++++
 rtl/edge_detector_bank.sv | 49 ++++
 3 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: mode field type and encodings shared by edge_chan and edge_detector_bank
package edge_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel; signal -> synchroniser -> debounce filter -> level, rise/fall/event pulses, sticky event_flag (flag_next feeds the bank irq)
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  signal,
  input  mode_t mode,
  input  logic  clear,
  output logic  level,
  output logic  rise_pulse,
  output logic  fall_pulse,
  output logic  event_pulse,
  output logic  event_flag,
  output logic  flag_next
);
  localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, event_q, event_d, flag_q, flag_d;
  logic sync, diff, commit;
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], signal};
    sync    = sync_q[SYNC_STAGES-1];
    diff    = sync != level_q;
    commit  = diff && cnt_q == CW'(FILTER_CYCLES - 1);
    cnt_d   = (diff && !commit) ? cnt_q + 1'b1 : '0;
    level_d = commit ? sync : level_q;
    rise_d  = commit & sync;
    fall_d  = commit & ~sync;
    event_d = (rise_d & |(mode & MODE_RISE)) | (fall_d & |(mode & MODE_FALL));
    flag_d  = event_d | (flag_q & ~clear);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
      flag_q  <= flag_d;
    end
  end
  assign level       = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_pulse = event_q;
  assign event_flag  = flag_q;
  assign flag_next   = flag_d;
endmodule

// File: rtl/edge_detector_bank.sv
// edge_detector_bank: WIDTH debounced edge-detect channels with sticky flags and a masked, registered irq
module edge_detector_bank
  import edge_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   signal,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   rise_pulse,
  output logic [WIDTH-1:0]   fall_pulse,
  output logic [WIDTH-1:0]   event_pulse,
  output logic [WIDTH-1:0]   event_flag,
  output logic               irq
);
  logic [WIDTH-1:0] flag_next;
  logic irq_q, irq_d;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .signal     (signal[i]),
      .mode       (mode[2*i+:2]),
      .clear      (clear[i]),
      .level      (level[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .event_pulse(event_pulse[i]),
      .event_flag (event_flag[i]),
      .flag_next  (flag_next[i])
    );
  end
  always_comb irq_d = |(flag_next & irq_en);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq = irq_q;
endmodule
